// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: opcodes, ALU op codes and the decode control bundle.
package pipe_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    typedef struct packed {
        logic       regDst;
        logic       branch;
        logic       memRead;
        logic       memToReg;
        logic [1:0] aluOp;
        logic       memWrite;
        logic       aluSrc;
        logic       regWrite;
        logic       jump;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    // An if() on an unknown condition takes the else branch, so X resolves to 0.
    function automatic logic toBit(input logic b);
        if (b) return 1'b1;
        else   return 1'b0;
    endfunction

    // Decode leaves don't-care controls undriven; make the captured bundle clean.
    function automatic ctrl_t sanitize(input ctrl_t raw);
        ctrl_t c;
        c.regWrite = toBit(raw.regWrite);
        c.jump     = toBit(raw.jump);
        c.regDst   = toBit(raw.regDst)   & c.regWrite;
        c.memToReg = toBit(raw.memToReg) & c.regWrite;
        c.aluSrc   = toBit(raw.aluSrc)   & ~c.jump;
        c.branch   = toBit(raw.branch);
        c.memRead  = toBit(raw.memRead);
        c.memWrite = toBit(raw.memWrite);
        c.aluOp    = {toBit(raw.aluOp[1]), toBit(raw.aluOp[0])};
        return c;
    endfunction

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Load-use hazard check of the instruction in EX against the one in decode.
module load_use_detect
    import pipe_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  exMemRead,
    input  logic                  exValid,
    input  logic [REG_ADDR_W-1:0] exRt,
    input  logic [REG_ADDR_W-1:0] idRs,
    input  logic [REG_ADDR_W-1:0] idRt,
    input  logic                  flush,
    output logic                  hazard,
    output logic                  stall
);

    assign hazard = exMemRead & exValid & (exRt != '0) & ((exRt == idRs) | (exRt == idRt));
    // A wrong-path consumer is squashed anyway, so no need to hold upstream.
    assign stall  = hazard & ~flush;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall generation and bubble insertion.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  reg_dst_i,
    input  logic                  branch_i,
    input  logic                  mem_read_i,
    input  logic                  mem_to_reg_i,
    input  logic [1:0]            alu_op_i,
    input  logic                  mem_write_i,
    input  logic                  alu_src_i,
    input  logic                  reg_write_i,
    input  logic                  jump_i,
    input  logic [DATA_W-1:0]     pc_plus4_i,
    input  logic [DATA_W-1:0]     rd_data1_i,
    input  logic [DATA_W-1:0]     rd_data2_i,
    input  logic [DATA_W-1:0]     imm_i,
    input  logic [REG_ADDR_W-1:0] rs_i,
    input  logic [REG_ADDR_W-1:0] rt_i,
    input  logic [REG_ADDR_W-1:0] rd_i,
    input  logic [5:0]            funct_i,
    input  logic                  flush_i,
    output logic                  stall_o,
    output logic                  reg_dst_o,
    output logic                  branch_o,
    output logic                  mem_read_o,
    output logic                  mem_to_reg_o,
    output logic [1:0]            alu_op_o,
    output logic                  mem_write_o,
    output logic                  alu_src_o,
    output logic                  reg_write_o,
    output logic                  jump_o,
    output logic [DATA_W-1:0]     pc_plus4_o,
    output logic [DATA_W-1:0]     rd_data1_o,
    output logic [DATA_W-1:0]     rd_data2_o,
    output logic [DATA_W-1:0]     imm_o,
    output logic [REG_ADDR_W-1:0] rs_o,
    output logic [REG_ADDR_W-1:0] rt_o,
    output logic [REG_ADDR_W-1:0] rd_o,
    output logic [5:0]            funct_o,
    output logic                  valid_o,
    output logic [CNT_W-1:0]      bubble_cnt_o
);

    ctrl_t            ctrlQ;
    ctrl_t            ctrlIn;
    logic             hazard;
    logic             stallRaw;
    logic             bubble;
    logic [CNT_W-1:0] bubbleCnt;

    load_use_detect #(.REG_ADDR_W(REG_ADDR_W)) uHazard (
        .exMemRead (ctrlQ.memRead),
        .exValid   (valid_o),
        .exRt      (rt_o),
        .idRs      (rs_i),
        .idRt      (rt_i),
        .flush     (flush_i),
        .hazard    (hazard),
        .stall     (stallRaw)
    );

    assign stall_o = stallRaw & ~rst;
    assign bubble  = flush_i | hazard;

    assign ctrlIn = sanitize('{regDst:   reg_dst_i,
                               branch:   branch_i,
                               memRead:  mem_read_i,
                               memToReg: mem_to_reg_i,
                               aluOp:    alu_op_i,
                               memWrite: mem_write_i,
                               aluSrc:   alu_src_i,
                               regWrite: reg_write_i,
                               jump:     jump_i});

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrlQ      <= CTRL_BUBBLE;
            valid_o    <= 1'b0;
            bubbleCnt  <= '0;
            pc_plus4_o <= '0;
            rd_data1_o <= '0;
            rd_data2_o <= '0;
            imm_o      <= '0;
            rs_o       <= '0;
            rt_o       <= '0;
            rd_o       <= '0;
            funct_o    <= '0;
        end else begin
            // Data and specifiers load even on a bubble; valid_o masks them.
            pc_plus4_o <= pc_plus4_i;
            rd_data1_o <= rd_data1_i;
            rd_data2_o <= rd_data2_i;
            imm_o      <= imm_i;
            rs_o       <= rs_i;
            rt_o       <= rt_i;
            rd_o       <= rd_i;
            funct_o    <= funct_i;
            if (bubble) begin
                ctrlQ   <= CTRL_BUBBLE;
                valid_o <= 1'b0;
                if (bubbleCnt != '1)
                    bubbleCnt <= bubbleCnt + CNT_W'(1);
            end else begin
                ctrlQ   <= ctrlIn;
                valid_o <= 1'b1;
            end
        end
    end

    assign reg_dst_o    = ctrlQ.regDst;
    assign branch_o     = ctrlQ.branch;
    assign mem_read_o   = ctrlQ.memRead;
    assign mem_to_reg_o = ctrlQ.memToReg;
    assign alu_op_o     = ctrlQ.aluOp;
    assign mem_write_o  = ctrlQ.memWrite;
    assign alu_src_o    = ctrlQ.aluSrc;
    assign reg_write_o  = ctrlQ.regWrite;
    assign jump_o       = ctrlQ.jump;
    assign bubble_cnt_o = bubbleCnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized and directed checks of id_ex_stage against a behavioural model of the stage.
module tb_id_ex_stage;

    localparam int CNT_W   = 5;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic        clk, rst;
    logic        reg_dst_i, branch_i, mem_read_i, mem_to_reg_i;
    logic [1:0]  alu_op_i;
    logic        mem_write_i, alu_src_i, reg_write_i, jump_i;
    logic [31:0] pc_plus4_i, rd_data1_i, rd_data2_i, imm_i;
    logic [4:0]  rs_i, rt_i, rd_i;
    logic [5:0]  funct_i;
    logic        flush_i;
    logic        stall_o;
    logic        reg_dst_o, branch_o, mem_read_o, mem_to_reg_o;
    logic [1:0]  alu_op_o;
    logic        mem_write_o, alu_src_o, reg_write_o, jump_o;
    logic [31:0] pc_plus4_o, rd_data1_o, rd_data2_o, imm_o;
    logic [4:0]  rs_o, rt_o, rd_o;
    logic [5:0]  funct_o;
    logic        valid_o;
    logic [CNT_W-1:0] bubble_cnt_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          regDst, branch, memRead, memToReg, memWrite, aluSrc, regWrite, jump, valid;
        bit [1:0]    aluOp;
        bit [31:0]   pc, d1, d2, imm;
        bit [4:0]    rs, rt, rd;
        bit [5:0]    funct;
        int          cnt;
    } exp_t;

    exp_t m;

    id_ex_stage #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .reg_dst_i(reg_dst_i), .branch_i(branch_i), .mem_read_i(mem_read_i),
        .mem_to_reg_i(mem_to_reg_i), .alu_op_i(alu_op_i), .mem_write_i(mem_write_i),
        .alu_src_i(alu_src_i), .reg_write_i(reg_write_i), .jump_i(jump_i),
        .pc_plus4_i(pc_plus4_i), .rd_data1_i(rd_data1_i), .rd_data2_i(rd_data2_i),
        .imm_i(imm_i), .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i), .funct_i(funct_i),
        .flush_i(flush_i), .stall_o(stall_o),
        .reg_dst_o(reg_dst_o), .branch_o(branch_o), .mem_read_o(mem_read_o),
        .mem_to_reg_o(mem_to_reg_o), .alu_op_o(alu_op_o), .mem_write_o(mem_write_o),
        .alu_src_o(alu_src_o), .reg_write_o(reg_write_o), .jump_o(jump_o),
        .pc_plus4_o(pc_plus4_o), .rd_data1_o(rd_data1_o), .rd_data2_o(rd_data2_o),
        .imm_o(imm_o), .rs_o(rs_o), .rt_o(rt_o), .rd_o(rd_o), .funct_o(funct_o),
        .valid_o(valid_o), .bubble_cnt_o(bubble_cnt_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit isOne(input logic b);
        return b === 1'b1;
    endfunction

    // One cycle: check stall against the model, advance the model, then check every output.
    task automatic tick();
        bit hz, bub, expStall;
        #1;
        hz = m.memRead && m.valid && (m.rt != 0) && (m.rt == rs_i || m.rt == rt_i);
        expStall = hz && !isOne(flush_i) && !isOne(rst);
        chk("stall", stall_o, expStall);
        if (isOne(rst)) begin
            m = '{default: 0};
        end else begin
            bub = isOne(flush_i) || hz;
            m.pc = pc_plus4_i; m.d1 = rd_data1_i; m.d2 = rd_data2_i; m.imm = imm_i;
            m.rs = rs_i; m.rt = rt_i; m.rd = rd_i; m.funct = funct_i;
            if (bub) begin
                m.regDst = 0; m.branch = 0; m.memRead = 0; m.memToReg = 0; m.aluOp = 0;
                m.memWrite = 0; m.aluSrc = 0; m.regWrite = 0; m.jump = 0; m.valid = 0;
                if (m.cnt < CNT_MAX) m.cnt++;
            end else begin
                m.regWrite = isOne(reg_write_i);
                m.regDst   = m.regWrite && isOne(reg_dst_i);
                m.memToReg = m.regWrite && isOne(mem_to_reg_i);
                m.jump     = isOne(jump_i);
                m.aluSrc   = isOne(alu_src_i) && !m.jump;
                m.branch   = isOne(branch_i);
                m.memRead  = isOne(mem_read_i);
                m.memWrite = isOne(mem_write_i);
                m.aluOp    = {isOne(alu_op_i[1]), isOne(alu_op_i[0])};
                m.valid    = 1;
            end
        end
        @(posedge clk);
        #1;
        chk("reg_dst", reg_dst_o, m.regDst);
        chk("branch", branch_o, m.branch);
        chk("mem_read", mem_read_o, m.memRead);
        chk("mem_to_reg", mem_to_reg_o, m.memToReg);
        chk("alu_op", alu_op_o, m.aluOp);
        chk("mem_write", mem_write_o, m.memWrite);
        chk("alu_src", alu_src_o, m.aluSrc);
        chk("reg_write", reg_write_o, m.regWrite);
        chk("jump", jump_o, m.jump);
        chk("pc_plus4", pc_plus4_o, m.pc);
        chk("rd_data1", rd_data1_o, m.d1);
        chk("rd_data2", rd_data2_o, m.d2);
        chk("imm", imm_o, m.imm);
        chk("rs", rs_o, m.rs);
        chk("rt", rt_o, m.rt);
        chk("rd", rd_o, m.rd);
        chk("funct", funct_o, m.funct);
        chk("valid", valid_o, m.valid);
        chk("bubble_cnt", bubble_cnt_o, 64'(m.cnt));
        @(negedge clk);
    endtask

    task automatic clearIns();
        {reg_dst_i, branch_i, mem_read_i, mem_to_reg_i, mem_write_i, alu_src_i, reg_write_i, jump_i} = '0;
        alu_op_i = 2'b00; flush_i = 0;
        pc_plus4_i = 32'h100; rd_data1_i = 0; rd_data2_i = 0; imm_i = 0;
        rs_i = 0; rt_i = 0; rd_i = 0; funct_i = 0;
    endtask

    task automatic randIns();
        {reg_dst_i, branch_i, mem_read_i, mem_to_reg_i, mem_write_i, alu_src_i, reg_write_i, jump_i} = 8'($urandom);
        alu_op_i = 2'($urandom);
        pc_plus4_i = $urandom; rd_data1_i = $urandom; rd_data2_i = $urandom; imm_i = $urandom;
        rs_i = 5'($urandom_range(0, 3)); rt_i = 5'($urandom_range(0, 3)); rd_i = 5'($urandom);
        funct_i = 6'($urandom);
        flush_i = ($urandom_range(0, 9) == 0);
    endtask

    task automatic loadWord(input logic [4:0] base, input logic [4:0] dst);
        clearIns();
        mem_read_i = 1; mem_to_reg_i = 1; reg_write_i = 1; alu_src_i = 1;
        rs_i = base; rt_i = dst;
    endtask

    task automatic addR(input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
        clearIns();
        reg_dst_i = 1; reg_write_i = 1; alu_op_i = 2'b10; funct_i = 6'h20;
        rs_i = s; rt_i = t; rd_i = d;
    endtask

    initial begin
        m = '{default: 0};
        rst = 1;
        randIns();
        @(negedge clk);
        // Reset with random inputs
        for (int i = 0; i < 2; i++) begin
            randIns();
            tick();
        end
        chk("rst_valid", valid_o, 1'b0);
        chk("rst_cnt", bubble_cnt_o, 0);
        rst = 0;

        // R-type add
        addR(5'd3, 5'd4, 5'd5);
        rd_data1_i = 32'h11; rd_data2_i = 32'h22;
        tick();
        chk("add_d1", rd_data1_o, 32'h11);
        chk("add_regdst", reg_dst_o, 1'b1);
        chk("add_aluop", alu_op_o, 2'b10);
        chk("add_valid", valid_o, 1'b1);

        // lw $8,0($9) then add $10,$8,$2
        loadWord(5'd9, 5'd8);
        tick();
        addR(5'd8, 5'd2, 5'd10);
        #1 chk("lu_stall", stall_o, 1'b1);
        tick();
        chk("lu_bubble_valid", valid_o, 1'b0);
        chk("lu_bubble_rw", reg_write_o, 1'b0);
        chk("lu_cnt", bubble_cnt_o, 1);
        tick();
        chk("lu_held_valid", valid_o, 1'b1);
        chk("lu_held_rd", rd_o, 5'd10);

        // lw $0 never stalls
        loadWord(5'd9, 5'd0);
        tick();
        addR(5'd0, 5'd0, 5'd7);
        #1 chk("lw0_stall", stall_o, 1'b0);
        tick();
        chk("lw0_valid", valid_o, 1'b1);

        // flush together with load-use
        loadWord(5'd1, 5'd8);
        tick();
        addR(5'd8, 5'd2, 5'd10);
        flush_i = 1;
        #1 chk("fl_stall", stall_o, 1'b0);
        tick();
        chk("fl_cnt", bubble_cnt_o, 2);
        chk("fl_valid", valid_o, 1'b0);

        // sanitisation of undriven controls
        clearIns();
        mem_write_i = 1; alu_src_i = 1; reg_dst_i = 1'bx; mem_to_reg_i = 1'bx; rs_i = 5'd2; rt_i = 5'd3;
        tick();
        chk("sw_regdst", reg_dst_o, 1'b0);
        chk("sw_memtoreg", mem_to_reg_o, 1'b0);
        clearIns();
        jump_i = 1; alu_src_i = 1'bx;
        tick();
        chk("j_alusrc", alu_src_o, 1'b0);
        chk("j_jump", jump_o, 1'b1);

        // reset during a stall
        loadWord(5'd1, 5'd6);
        tick();
        addR(5'd6, 5'd6, 5'd1);
        rst = 1;
        tick();
        chk("rs_valid", valid_o, 1'b0);
        chk("rs_cnt", bubble_cnt_o, 0);
        rst = 0;
        tick();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            randIns();
            if (i % 3 == 0) mem_read_i = 1;
            rst = ($urandom_range(0, 49) == 0);
            tick();
        end

        // counter saturation
        rst = 1; clearIns(); tick(); rst = 0;
        for (int i = 0; i < CNT_MAX + 3; i++) begin
            clearIns(); flush_i = 1;
            tick();
        end
        chk("sat_cnt", bubble_cnt_o, CNT_MAX);
        tick();
        chk("sat_hold", bubble_cnt_o, CNT_MAX);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline boundary for the 32-bit 5-stage pipelined processor. Registers the decode-stage control bundle produced by the main control decoder, together with the operands, immediate, register specifiers and PC+4, for use by the EX stage. Detects load-use hazards against its own registered contents and raises a stall. Inserts a bubble (all-zero control) on a stall or on a branch/jump flush.

Parameters:
DATA_W, 32, width of PC, operand and immediate paths
REG_ADDR_W, 5, register specifier width
CNT_W, 16, width of the saturating bubble counter

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
reg_dst_i  in  1  decode control: select rd as destination
branch_i  in  1  decode control: beq
mem_read_i  in  1  decode control: load
mem_to_reg_i  in  1  decode control: writeback from memory
alu_op_i  in  2  decode control: 00 add, 01 sub/compare, 10 funct-decoded
mem_write_i  in  1  decode control: store
alu_src_i  in  1  decode control: immediate operand B
reg_write_i  in  1  decode control: register write
jump_i  in  1  decode control: jump
pc_plus4_i  in  DATA_W  PC+4 of the decode instruction
rd_data1_i  in  DATA_W  register file port 1 (rs)
rd_data2_i  in  DATA_W  register file port 2 (rt)
imm_i  in  DATA_W  sign-extended immediate
rs_i, rt_i, rd_i  in  REG_ADDR_W each  instruction register fields
funct_i  in  6  function field
flush_i  in  1  branch taken or jump resolved downstream; the decode instruction is wrong-path
stall_o  out  1  hold PC and IF/ID this cycle
reg_dst_o, branch_o, mem_read_o, mem_to_reg_o, mem_write_o, alu_src_o, reg_write_o, jump_o  out  1 each  registered control
alu_op_o  out  2  registered ALU op
pc_plus4_o, rd_data1_o, rd_data2_o, imm_o  out  DATA_W  registered data
rs_o, rt_o, rd_o  out  REG_ADDR_W  registered specifiers
funct_o  out  6  registered funct
valid_o  out  1  1 = real instruction, 0 = bubble
bubble_cnt_o  out  CNT_W  number of bubbles inserted, saturating

Behaviour:
- Latency: 1 cycle. Every output register updates on each rising clk. There is no hold state, because a stall is realised as a bubble here while upstream holds.
- Reset (rst=1 at the edge): all control outputs 0, alu_op_o=00, all data and specifier outputs 0, valid_o=0, bubble_cnt_o=0. Reset has priority over everything.
- Hazard detection is combinational on the registered state:
  - hazard = mem_read_o & valid_o & (rt_o != 0) & ((rt_o == rs_i) | (rt_o == rt_i)).
  - stall_o = hazard & ~flush_i. stall_o is 0 while rst=1.
- Bubble condition: bubble = flush_i | hazard.
  - On a bubble edge: all control outputs 0, alu_op_o=00, valid_o=0.
  - Data and specifier registers still load their inputs; their values are don't-care functionally but must be deterministic.
  - bubble_cnt_o increments by 1 and saturates at all-ones.
- Normal edge (no bubble): every input is captured and valid_o=1.
- Sanitisation applies on capture. Decode drives X on don't-care controls, so the register must never hold X:
  - reg_write_i=0 forces reg_dst_o=0 and mem_to_reg_o=0.
  - jump_i=1 forces alu_src_o=0.
  - Any X on the remaining inputs while reg_write_i=0 resolves to 0.
- Simultaneous flush and hazard: flush wins. One bubble is inserted, stall_o=0, and the counter increments once.
- A load-use stall lasts exactly one cycle. The following cycle holds a bubble (mem_read_o=0), so hazard drops unless flushed.
- Reset asserted during a stall: the next edge gives the reset state, and stall_o=0 from that edge on.

Decomposition:
- Shared package pipe_pkg:
  - opcode constants: OP_RTYPE=000000, OP_LW=100011, OP_SW=101011, OP_BEQ=000100, OP_J=000010
  - ALU_OP constants: ADD=00, SUB=01, FUNCT=10
  - packed struct ctrl_t holding the nine decode controls, and constant CTRL_BUBBLE (all zero)
- One sub-module load_use_detect: combinational. Inputs: ex mem_read, valid, rt, plus id rs, rt, flush. Outputs: hazard, stall.

Test Plan:
1. rst=1 for 2 cycles with random inputs -> all outputs 0, valid_o=0, stall_o=0, bubble_cnt_o=0.
2. R-type add (reg_dst=1, alu_op=10, reg_write=1, rs=3, rt=4, rd=5, rd_data1=0x11, rd_data2=0x22) -> next cycle outputs match, valid_o=1, stall_o=0.
3. lw $8,0($9) then add $10,$8,$2 -> cycle after the lw capture: stall_o=1. Next edge: bubble (valid_o=0, reg_write_o=0, bubble_cnt_o=1). The held add is captured one cycle later with valid_o=1.
4. lw $0 followed by a consumer of $0 -> stall_o stays 0 and no bubble is inserted.
5. flush_i=1 together with a load-use hazard -> stall_o=0, a single bubble, bubble_cnt_o increments by exactly 1.
6. sw with reg_dst_i=X and mem_to_reg_i=X, then j with alu_src_i=X -> reg_dst_o=0, mem_to_reg_o=0, alu_src_o=0, no X on any output. Separately, force bubble_cnt to all-ones and apply one more bubble -> the count stays all-ones.
